// File: rtl/pc_unit.sv
// Fetch-stage program counter: stall hold, prioritised redirects, a pending
// redirect captured during stalls, and a circular call/return address stack.
module pc_unit #(
  parameter int unsigned          PC_WIDTH     = 16,
  parameter int unsigned          STEP         = 1,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0]  EXC_VECTOR   = PC_WIDTH'('h0080),
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                exc_req,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                jmp,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_next_seq,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err,
  output logic                redirect_pending
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pend_v_q, pend_v_d;
  logic                pend_exc_q, pend_exc_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [PW-1:0]       top_q, top_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                push;
  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];

  assign pc_out           = pc_q;
  assign pc_next_seq      = pc_q + PC_WIDTH'(STEP);
  assign ras_empty        = (cnt_q == '0);
  assign ras_full         = (cnt_q == CW'(RAS_DEPTH));
  assign ras_err          = err_q;
  assign redirect_pending = pend_v_q;

  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_exc_d = pend_exc_q;
    pend_tgt_d = pend_tgt_q;
    top_d      = top_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    push       = 1'b0;
    if (stall) begin
      // A pending exception is never displaced by a branch; branches overwrite branches.
      if (exc_req) begin
        pend_v_d   = 1'b1;
        pend_exc_d = 1'b1;
        pend_tgt_d = EXC_VECTOR;
      end else if (br_taken && !(pend_v_q && pend_exc_q)) begin
        pend_v_d   = 1'b1;
        pend_exc_d = 1'b0;
        pend_tgt_d = br_target;
      end
    end else begin
      pend_v_d   = 1'b0;
      pend_exc_d = 1'b0;
      if (exc_req) begin
        pc_d  = EXC_VECTOR;
        cnt_d = '0;
      end else if (br_taken) begin
        pc_d = br_target;
      end else if (pend_v_q) begin
        pc_d = pend_tgt_q;
        if (pend_exc_q) cnt_d = '0;
      end else if (ret) begin
        if (cnt_q == '0) begin
          pc_d  = pc_next_seq;
          err_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_q];
          top_d = top_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end else if (jmp) begin
        pc_d = jmp_target;
        if (call) begin
          // When full the new entry lands on the oldest slot; count saturates.
          push  = 1'b1;
          top_d = top_q + 1'b1;
          if (!ras_full) cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pc_d = pc_next_seq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      pend_v_q   <= 1'b0;
      pend_exc_q <= 1'b0;
      pend_tgt_q <= '0;
      top_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_exc_q <= pend_exc_d;
      pend_tgt_q <= pend_tgt_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_q[top_d] <= pc_next_seq;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, exc_req, br_taken, jmp, call, ret;
  logic [15:0] br_target, jmp_target;
  logic [15:0] pc_out, pc_next_seq;
  logic        ras_empty, ras_full, ras_err, redirect_pending;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .PC_WIDTH    (16),
    .STEP        (1),
    .RESET_VECTOR(16'h0000),
    .EXC_VECTOR  (16'h0080),
    .RAS_DEPTH   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .exc_req         (exc_req),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .jmp             (jmp),
    .jmp_target      (jmp_target),
    .call            (call),
    .ret             (ret),
    .pc_out          (pc_out),
    .pc_next_seq     (pc_next_seq),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_err         (ras_err),
    .redirect_pending(redirect_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; exc_req = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
  endtask

  initial begin
    rst = 0; idle(); br_target = '0; jmp_target = '0;
    tick(); tick();
    check("reset_pc", pc_out, 16'h0000);
    check("reset_empty", ras_empty, 1);
    check("reset_full", ras_full, 0);
    check("reset_err", ras_err, 0);
    check("reset_pend", redirect_pending, 0);

    // Async reset mid-cycle from a non-zero PC
    rst = 1; tick(); tick();
    check("pre_async_pc", pc_out, 16'h0002);
    #2 rst = 0; #1;
    check("async_reset_pc", pc_out, 16'h0000);
    #1 rst = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", pc_out, i);
      check("seq_next", pc_next_seq, i + 1);
    end

    // Stall hold with a branch captured in stall cycle 2
    tick(); tick();
    check("pc_5", pc_out, 16'h0005);
    stall = 1; tick();
    br_taken = 1; br_target = 16'h0040; tick();
    check("stall_pc", pc_out, 16'h0005);
    check("stall_pend", redirect_pending, 1);
    br_taken = 0; tick();
    check("stall3_pc", pc_out, 16'h0005);
    stall = 0; tick();
    check("pend_applied_pc", pc_out, 16'h0040);
    check("pend_cleared", redirect_pending, 0);

    // Push an entry, then a pending exception must beat a later pending branch
    jmp = 1; call = 1; jmp_target = 16'h0060; tick();
    jmp = 0; call = 0;
    check("call_nonempty", ras_empty, 0);
    stall = 1; exc_req = 1; tick();
    exc_req = 0; br_taken = 1; br_target = 16'h0200; tick();
    check("exc_hold_pc", pc_out, 16'h0060);
    br_taken = 0; stall = 0; tick();
    check("exc_pend_pc", pc_out, 16'h0080);
    check("exc_pend_flush", ras_empty, 1);

    // Later pending branch overwrites an earlier one
    stall = 1; br_taken = 1; br_target = 16'h0300; tick();
    br_target = 16'h0310; tick();
    br_taken = 0; stall = 0; tick();
    check("br_overwrite_pc", pc_out, 16'h0310);

    // Call/return
    jmp = 1; jmp_target = 16'h0010; tick();
    call = 1; jmp_target = 16'h0100; tick();
    idle();
    check("call_pc", pc_out, 16'h0100);
    check("call_ras", ras_empty, 0);
    tick(); tick();
    check("after_call_seq", pc_out, 16'h0102);
    ret = 1; tick(); ret = 0;
    check("ret_pc", pc_out, 16'h0011);
    check("ret_empty", ras_empty, 1);

    // Overflow: five calls from pcs 1..5, then pops
    jmp = 1; jmp_target = 16'h0001; tick();
    call = 1;
    for (int i = 1; i <= 5; i++) begin
      jmp_target = 16'(i + 1); tick();
    end
    idle();
    check("ovf_full", ras_full, 1);
    ret = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pop_pc", pc_out, 6 - i);
    end
    check("pop_empty", ras_empty, 1);
    check("no_err_yet", ras_err, 0);
    tick();
    check("underflow_pc", pc_out, 16'h0004);
    check("underflow_err", ras_err, 1);
    ret = 0; tick();
    check("err_pulse_end", ras_err, 0);

    // Wrap
    jmp = 1; jmp_target = 16'hFFFF; tick(); jmp = 0;
    check("wrap_next", pc_next_seq, 16'h0000);
    tick();
    check("wrap_pc", pc_out, 16'h0000);

    // All sources together: exception wins and only the flush touches the RAS
    jmp = 1; call = 1; jmp_target = 16'h0030; tick();
    check("prio_pre_empty", ras_empty, 0);
    exc_req = 1; br_taken = 1; br_target = 16'h0500; ret = 1; tick();
    idle();
    check("prio_pc", pc_out, 16'h0080);
    check("prio_empty", ras_empty, 1);
    check("prio_full", ras_full, 0);
    check("prio_err", ras_err, 0);

    // Reset drops a captured redirect
    stall = 1; br_taken = 1; br_target = 16'h0700; tick();
    check("pend_before_rst", redirect_pending, 1);
    #2 rst = 0; #1;
    check("rst_pend_lost", redirect_pending, 0);
    check("rst_pc", pc_out, 16'h0000);
    #1 rst = 1; idle(); tick();
    check("post_rst_pc", pc_out, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the pipelined MIPS fetch stage; successor to the basic 16-bit PC register.
- Adds stall hold, prioritised redirects (exception, branch, return, jump) and a call/return address stack.
- Adds a pending-redirect register so a redirect that arrives during a stall is never lost.
- Drives the instruction-memory address and the sequential PC to the IF/ID register.

Parameters:
- PC_WIDTH, 16, PC and all target widths.
- STEP, 1, sequential increment (word-addressed instruction memory).
- RESET_VECTOR, 0, pc_out value after reset.
- EXC_VECTOR, 'h0080, exception handler address.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- stall  in  1  hazard unit: hold PC this cycle.
- exc_req  in  1  exception redirect request.
- br_taken  in  1  branch resolved taken.
- br_target  in  PC_WIDTH  branch target.
- jmp  in  1  decode-stage jump.
- jmp_target  in  PC_WIDTH  jump target.
- call  in  1  qualifies jmp as a call (push return address).
- ret  in  1  return: pop RAS top as target.
- pc_out  out  PC_WIDTH  current fetch address.
- pc_next_seq  out  PC_WIDTH  combinational pc_out+STEP, mod 2^PC_WIDTH.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  one-cycle pulse on underflow (ret while empty).
- redirect_pending  out  1  a captured redirect awaits stall release.

Behaviour:
- Reset (rst=0, async):
  - pc_out=RESET_VECTOR; RAS count=0, so ras_empty=1 and ras_full=0.
  - ras_err=0; pending register cleared, redirect_pending=0.
  - Release is synchronous to the next clk edge.
- Unstalled cycle (stall=0) next-PC priority:
  - 1) exc_req -> EXC_VECTOR; flush RAS (count=0).
  - 2) br_taken -> br_target.
  - 3) pending redirect -> its stored target.
  - 4) ret -> RAS top, pop.
  - 5) jmp -> jmp_target; if call also asserted, push pc_next_seq.
  - 6) otherwise pc_next_seq.
  - Pending is cleared on any unstalled edge, whether it was used or overridden.
  - A higher-priority source suppresses all RAS operations that cycle.
  - call without jmp is ignored.
- Stalled cycle (stall=1):
  - pc_out and RAS are unchanged.
  - exc_req is captured as pending with target EXC_VECTOR, a type bit marking it as an exception, and redirect_pending set.
  - br_taken is captured only if no exception is already pending; a later branch overwrites an earlier pending branch.
  - A pending exception flushes the RAS when it is applied.
  - jmp, call and ret are not captured during a stall; decode holds them until stall=0.
- Latency: a redirect asserted in cycle N with stall=0 appears on pc_out after edge N+1. A captured redirect appears after the first unstalled edge.
- RAS behaviour:
  - Circular buffer with a top pointer and a count.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH, ras_full stays 1.
  - ret while empty: pc <- pc_next_seq and ras_err pulses for one cycle; count stays 0.
  - ret and call+jmp in the same cycle: ret wins, no push.
- Arithmetic: all additions are modulo 2^PC_WIDTH. For PC_WIDTH=16, 'hFFFF+1 -> 'h0000 with no flag.
- Reset mid-operation: pending and RAS are lost, and pc_out returns to RESET_VECTOR immediately, without waiting for a clk edge.

Test Plan:
- Reset and sequence: assert rst=0 mid-cycle -> pc_out=0 immediately. Release rst, run 3 clean cycles -> pc_out 1, 2, 3; pc_next_seq always pc_out+1.
- Stall hold with pending: pc_out=5, stall=1 for 3 cycles, br_taken with 'h0040 in stall cycle 2 -> pc_out stays 5 and redirect_pending=1. First unstalled edge -> pc_out='h0040, redirect_pending=0.
- Exception beats pending branch: during stall, exc_req then br_taken 'h0200 -> after release pc_out='h0080 and ras_empty=1.
- Call/return: at pc_out='h0010, jmp+call to 'h0100 -> pc_out='h0100, ras_empty=0. Two sequential cycles, then ret -> pc_out='h0011, ras_empty=1.
- RAS overflow/underflow (RAS_DEPTH=4): 5 calls from pcs 1..5 -> ras_full=1; 4 rets -> targets 6, 5, 4, 3. 5th ret -> ras_err pulses and pc_out=pc+1.
- Wrap and priority: pc_out='hFFFF, no redirect -> 'h0000. exc_req, br_taken, ret and jmp in the same cycle -> pc_out='h0080 and RAS unchanged apart from the flush.
